// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write path.
package regfile_pkg;

    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int NREGS     = 32;
    localparam int GID_W     = 3;
    localparam int MAX_NREQ  = 8;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

    // One-hot view of a register write; x0 never shows up as in flight.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] addr, input logic we);
        logic [NREGS-1:0] m;
        m = '0;
        if (we && addr != REG_ZERO) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Two passes (upper segment from ptr, then the wrapped lower segment) keep every index constant.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = PW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ requesters, round-robin,
// with a registered issue stage, x0 write filtering and an in-flight mask.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]      rg_A3,
    output logic [DW-1:0]      rg_WD3,
    output logic               rg_WE3,
    output logic [31:0]        inflight_mask,
    output logic [2:0]         grant_id
);
    import regfile_pkg::*;

    localparam int GW = GID_W;

    generate
        if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
            $error("regfile_write_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    logic [GW-1:0]   rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [GW-1:0]   gidx;
    logic            gvalid;
    logic [GW-1:0]   ptr_next;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .N  (NREQ),
        .PW (GW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gvalid)
    );

    // The issue stage is held in reset too, so gating ready keeps the handshake consistent.
    assign req_ready = reset ? '0 : gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rg_A3    <= '0;
            rg_WD3   <= '0;
            rg_WE3   <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (gvalid) begin
            rg_A3    <= sel_addr;
            rg_WD3   <= sel_data;
            rg_WE3   <= (sel_addr != '0);
            grant_id <= gidx;
            rr_ptr   <= ptr_next;
        end else begin
            rg_WE3   <= 1'b0;
        end
    end

    assign inflight_mask = reg_onehot(rg_A3, rg_WE3);

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between NREQ writeback requesters (default 3: ALU writeback, load unit, debug/CSR path). Each requester uses a valid/ready handshake, and the block grants one requester per cycle in round-robin order. The granted write is registered and driven onto the register-file write port (rg_A3, rg_WD3, rg_WE3) one cycle later. The block also keeps a one-cycle in-flight scoreboard so hazard logic can see which register is being written.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  requester i has a write pending
req_addr  input  NREQ*AW  destination address, slice i = [i*AW +: AW]
req_data  input  NREQ*DW  write data, slice i = [i*DW +: DW]
req_ready  output  NREQ  one-hot grant; a transfer completes when valid&ready in the same cycle
rg_A3  output  AW  register-file write address (registered)
rg_WD3  output  DW  register-file write data (registered)
rg_WE3  output  1  register-file write enable (registered)
inflight_mask  output  32  bit k=1 while register k is driven on the write port this cycle
grant_id  output  3  index of the last issued grant (registered)

Behaviour:
- Reset (async, active-high):
  - rg_A3=0, rg_WD3=0, rg_WE3=0, inflight_mask=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Arbitration is combinational each cycle:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid index g gets req_ready[g]=1; all other bits are 0.
  - If no requester is valid, req_ready is all zero.
  - req_ready never asserts for a requester whose valid is low.
- Issue on the clock edge after a grant:
  - rg_A3 <= addr[g], rg_WD3 <= data[g], grant_id <= g, rr_ptr <= (g+1) mod NREQ.
  - rg_WE3 <= 1 only if addr[g] != 0. Writes to x0 are accepted (ready=1) but dropped, with rg_WE3=0.
- Idle cycle (no grant):
  - rg_WE3 <= 0; rr_ptr, rg_A3, rg_WD3 and grant_id hold their values.
- Latency and throughput:
  - Exactly 1 cycle from handshake to write-port drive.
  - The register file commits on the following edge.
  - Throughput is one write per cycle; there is no backpressure from the register file.
- Fairness: any continuously valid requester is granted within NREQ cycles.
- Requester rules:
  - A requester must hold addr/data stable while valid is high and ready is low.
  - Dropping valid before the grant is legal; the request is withdrawn.
- inflight_mask:
  - Onehot(rg_A3) when rg_WE3=1, else 0. Derived from the registered outputs.
  - Never has bit 0 set.
- Same-address requests: two requesters targeting the same register are serialised in grant order. The later grant's data is the final register value.
- Reset mid-operation: a write latched in the output stage is discarded (rg_WE3 forced to 0). The pending requester is not acknowledged again; it must re-present its request after reset.
- Width rule: grant_id is zero-extended to 3 bits; NREQ>8 is illegal (elaboration-time check).

Decomposition:
- Shared package regfile_pkg:
  - Constants AW=5, DW=32, NREGS=32, REG_ZERO=5'd0.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
- One sub-module: rr_arbiter (parameter N; inputs req[N-1:0] and ptr; outputs one-hot gnt and encoded index).
- The top level adds the output register stage, the x0 filter and the scoreboard.

Test Plan:
- Reset then idle, no valid for 5 cycles -> rg_WE3=0, req_ready=0, inflight_mask=0 throughout.
- Single request: req0 valid, addr=5, data=0xDEADBEEF -> req_ready=3'b001 that cycle; next cycle rg_A3=5, rg_WD3=0xDEADBEEF, rg_WE3=1, inflight_mask=0x20.
- All three valid continuously for 6 cycles from rr_ptr=0 -> grant order 0,1,2,0,1,2; grant_id follows one cycle later.
- Write to x0: req1 valid, addr=0, data=0x1234 -> req_ready[1]=1; next cycle rg_WE3=0, inflight_mask=0; rr_ptr advances to 2.
- Same address: req0 and req2 both target addr=7 with data 0xA and 0xB, rr_ptr=0 -> 0xA issued, then 0xB; register 7 ends at 0xB.
- Async reset mid-operation: reset pulsed between edges while rg_WE3=1 -> rg_WE3 drops immediately without a clock; after release, first grant goes to the lowest valid index (rr_ptr=0).
